prog_memory: RTL and testbench

- Parametrised byte-addressable program memory for the 8-bit microprocessor.
- Loaded by the testbench through a valid/ready load port.
- Serves multi-byte instruction fetches to the control unit through a req/valid fetch port.
- Adds beyond the first-generation instruction memory: reset, a fully synchronous single clock, variable-length fetch with address wrap-around, per-location written flags with an uninitialised-read error, and a count of loaded locations.

---
 rtl/prog_mem_pkg.sv | 29 ++
 rtl/prog_memory_if.sv | 51 +++++
 rtl/prog_mem_array.sv | 51 +++++
 rtl/prog_memory.sv | 131 +++++++++++++
 tb/tb_prog_memory.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_mem_pkg.sv
// -----------------------------------------------------------------------------
// prog_mem_pkg
// Shared definitions for the program memory: default geometry, the control
// FSM state type, and small helpers for sizing and validating fetch lengths.
// -----------------------------------------------------------------------------
package prog_mem_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_MAX_BYTES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of the fetch length field: must hold 0..max_bytes.
    function automatic int fetch_len_w(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // A fetch must return at least one word and no more than the port holds.
    // Evaluated on ints so the range test stays meaningful for any width.
    function automatic logic len_is_legal(input int len, input int max_bytes);
        return (len >= 1) && (len <= max_bytes);
    endfunction

endpackage

// File: rtl/prog_memory_if.sv
// -----------------------------------------------------------------------------
// prog_memory_if
// Load and fetch ports of the program memory.
//   master : the loader / control unit (drives load_* and fetch_req/addr/len)
//   slave  : the program memory (drives load_ready, fetch_data/valid/err,
//            busy and load_count)
// -----------------------------------------------------------------------------
interface prog_memory_if
    import prog_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BYTES = DEF_MAX_BYTES
);
    localparam int LEN_W = fetch_len_w(MAX_BYTES);

    // load port
    logic                        load_valid;
    logic [ADDR_W-1:0]           load_addr;
    logic [DATA_W-1:0]           load_data;
    logic                        load_ready;

    // fetch port
    logic                        fetch_req;
    logic [ADDR_W-1:0]           fetch_addr;
    logic [LEN_W-1:0]            fetch_len;
    logic [DATA_W*MAX_BYTES-1:0] fetch_data;
    logic                        fetch_valid;
    logic                        fetch_err;

    // status
    logic                        busy;
    logic [ADDR_W:0]             load_count;

    modport master (
        output load_valid, load_addr, load_data,
        input  load_ready,
        output fetch_req, fetch_addr, fetch_len,
        input  fetch_data, fetch_valid, fetch_err,
        input  busy, load_count
    );

    modport slave (
        input  load_valid, load_addr, load_data,
        output load_ready,
        input  fetch_req, fetch_addr, fetch_len,
        output fetch_data, fetch_valid, fetch_err,
        output busy, load_count
    );

endinterface

// File: rtl/prog_mem_array.sv
// -----------------------------------------------------------------------------
// prog_mem_array
// Single-port storage with one "written" flag per location.
//   clk        : system clock, write on rising edge
//   rst        : async active-high, clears all written flags (data untouched)
//   we_i       : write enable
//   addr_i     : shared read/write address
//   wdata_i    : write data
//   rdata_o    : combinational read data at addr_i
//   written_o  : combinational written flag at addr_i
// -----------------------------------------------------------------------------
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              written_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written_q;

    // Contents are deliberately not reset; only the flags are.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flag
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                written_q[gi] <= 1'b0;
            end else if (we_i && (addr_i == ADDR_W'(gi))) begin
                written_q[gi] <= 1'b1;
            end
        end
    end

    assign rdata_o   = mem[addr_i];
    assign written_o = written_q[addr_i];

endmodule

// File: rtl/prog_memory.sv
// -----------------------------------------------------------------------------
// prog_memory
// Byte-addressable program memory with a valid/ready load port and a
// req/valid multi-word fetch port.
//   clk  : system clock, all logic on the rising edge
//   rst  : async active-high reset
//   bus  : prog_memory_if.slave
//          load_valid/addr/data -> load_ready
//          fetch_req/addr/len   -> fetch_data/valid/err
//          busy (FETCH or DONE), load_count (distinct locations written)
// Fetch reads one word per cycle starting at fetch_addr, wrapping modulo
// DEPTH; any unwritten location or an out-of-range length raises fetch_err.
// -----------------------------------------------------------------------------
module prog_memory
    import prog_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic         clk,
    input  logic         rst,
    prog_memory_if.slave bus
);
    localparam int LEN_W = fetch_len_w(MAX_BYTES);

    state_e                      state_q;
    logic [ADDR_W-1:0]           ptr_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            idx_q;
    logic [DATA_W*MAX_BYTES-1:0] data_q;
    logic                        err_q;
    logic                        valid_q;
    logic [ADDR_W:0]             count_q;

    logic                        load_fire;
    logic [ADDR_W-1:0]           arr_addr;
    logic [DATA_W-1:0]           rd_data;
    logic                        rd_written;

    assign bus.load_ready = (state_q == IDLE) && !rst;
    assign load_fire      = bus.load_valid && bus.load_ready;

    // One port serves both directions: loads only happen in IDLE and reads
    // only in FETCH, so the address can simply follow the state. In IDLE the
    // flag read at load_addr tells whether a load hits a fresh location.
    assign arr_addr = (state_q == FETCH) ? ptr_q : bus.load_addr;

    prog_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (load_fire),
        .addr_i    (arr_addr),
        .wdata_i   (bus.load_data),
        .rdata_o   (rd_data),
        .written_o (rd_written)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (load_fire) begin
                        // Load wins; a pending fetch_req waits for a free cycle.
                        if (!rd_written) begin
                            count_q <= count_q + 1'b1;
                        end
                    end else if (bus.fetch_req) begin
                        ptr_q  <= bus.fetch_addr;
                        len_q  <= bus.fetch_len;
                        idx_q  <= '0;
                        data_q <= '0;
                        if (len_is_legal(int'(bus.fetch_len), MAX_BYTES)) begin
                            err_q   <= 1'b0;
                            state_q <= FETCH;
                        end else begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                FETCH: begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (idx_q == LEN_W'(i)) begin
                            data_q[i*DATA_W +: DATA_W] <= rd_data;
                        end
                    end
                    err_q <= err_q | !rd_written;
                    ptr_q <= ptr_q + 1'b1;   // wraps DEPTH-1 -> 0 by width
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_data  = data_q;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.load_count  = count_q;

endmodule

// File: tb/tb_prog_memory.sv
module tb_prog_memory;
    import prog_mem_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int MB = 3;
    localparam int LW = fetch_len_w(MB);

    logic clk;
    logic rst;

    prog_memory_if #(.DATA_W(DW), .ADDR_W(AW), .MAX_BYTES(MB)) bus ();

    prog_memory #(.DATA_W(DW), .ADDR_W(AW), .MAX_BYTES(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DW*MB-1:0] data;
        logic             err;
        bit               chk_data;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        bit               is_load;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [LW-1:0]    len;
        logic [DW*MB-1:0] exp_data;
        logic             exp_err;
        bit               chk_data;
        int               exp_count;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All driving tasks start and end just after a falling edge.
    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_data  = d;
        check("load_ready", 32'(bus.load_ready), 32'd1);
        @(negedge clk);
        bus.load_valid = 1'b0;
        $display("load  addr=0x%02h data=0x%02h count=%0d", a, d, bus.load_count);
    endtask

    task automatic wait_valid(input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fetch_valid && n < 12);
        bus.fetch_req = 1'b0;
        if (!bus.fetch_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: no fetch_valid after %0d cycles, expected at %0d", n, exp_lat);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        check("fetch_latency", 32'(n), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: fetch_valid with no expected entry, got data 0x%0h", bus.fetch_data);
            return;
        end
        e = sb_q.pop_front();
        $display("fetch done data=0x%06h err=%0d lat=%0d", bus.fetch_data, bus.fetch_err, n);
        if (e.chk_data) check("fetch_data", 32'(bus.fetch_data), 32'(e.data));
        check("fetch_err", 32'(bus.fetch_err), 32'(e.err));
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.fetch_valid), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        if (e.chk_data) check("fetch_data_hold", 32'(bus.fetch_data), 32'(e.data));
        check("fetch_err_hold", 32'(bus.fetch_err), 32'(e.err));
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input logic [DW*MB-1:0] ed, input logic ee, input bit cd);
        exp_t e;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        bus.fetch_len  = l;
        e.data = ed;
        e.err = ee;
        e.chk_data = cd;
        sb_q.push_back(e);
        $display("fetch addr=0x%02h len=%0d", a, l);
        wait_valid((l >= 1 && int'(l) <= MB) ? int'(l) + 1 : 1);
    endtask

    initial begin
        exp_t e;

        //          ld  addr   data   len  exp_data     err   chk  count
        vecs[0]  = '{1, 8'h10, 8'h3E, 2'd0, 24'h0,       1'b0, 0,  -1};
        vecs[1]  = '{1, 8'h11, 8'hA5, 2'd0, 24'h0,       1'b0, 0,  -1};
        vecs[2]  = '{1, 8'h12, 8'h07, 2'd0, 24'h0,       1'b0, 0,  -1};
        vecs[3]  = '{0, 8'h10, 8'h00, 2'd3, 24'h07A53E,  1'b0, 1,   3};
        vecs[4]  = '{1, 8'hFF, 8'h11, 2'd0, 24'h0,       1'b0, 0,  -1};
        vecs[5]  = '{1, 8'h00, 8'h22, 2'd0, 24'h0,       1'b0, 0,  -1};
        vecs[6]  = '{0, 8'hFF, 8'h00, 2'd2, 24'h002211,  1'b0, 1,   5};
        vecs[7]  = '{0, 8'h40, 8'h00, 2'd1, 24'h0,       1'b1, 0,   5};
        vecs[8]  = '{0, 8'h00, 8'h00, 2'd0, 24'h000000,  1'b1, 1,   5};
        vecs[9]  = '{0, 8'h11, 8'h00, 2'd1, 24'h0000A5,  1'b0, 1,   5};
        vecs[10] = '{0, 8'h11, 8'h00, 2'd2, 24'h0007A5,  1'b0, 1,   5};
        vecs[11] = '{0, 8'hFE, 8'h00, 2'd3, 24'h0,       1'b1, 0,   5};

        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.fetch_len  = '0;

        repeat (2) @(negedge clk);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_load_count", 32'(bus.load_count), 32'd0);
        check("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
        check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.load_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_load) begin
                do_load(vecs[i].addr, vecs[i].data);
            end else begin
                do_fetch(vecs[i].addr, vecs[i].len, vecs[i].exp_data, vecs[i].exp_err, vecs[i].chk_data);
                if (vecs[i].exp_count >= 0)
                    check("load_count", 32'(bus.load_count), 32'(vecs[i].exp_count));
            end
        end

        // Load and fetch requested together: two loads first, fetch on the third edge.
        bus.load_valid = 1'b1;
        bus.load_addr  = 8'h20;
        bus.load_data  = 8'h99;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h20;
        bus.fetch_len  = 2'd2;
        e.data = 24'h009899;
        e.err = 1'b0;
        e.chk_data = 1;
        sb_q.push_back(e);
        $display("load+fetch addr=0x20 data=0x99 / fetch addr=0x20 len=2");
        @(negedge clk);
        check("prio_busy_c1", 32'(bus.busy), 32'd0);
        bus.load_addr = 8'h21;
        bus.load_data = 8'h98;
        $display("load+fetch addr=0x21 data=0x98");
        @(negedge clk);
        check("prio_busy_c2", 32'(bus.busy), 32'd0);
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("prio_busy_fetch", 32'(bus.busy), 32'd1);
        check("prio_ready_stall", 32'(bus.load_ready), 32'd0);
        wait_valid(2);
        check("prio_load_count", 32'(bus.load_count), 32'd7);

        // Rewrite a location: data replaced, count unchanged.
        do_load(8'h10, 8'h55);
        check("rewrite_count", 32'(bus.load_count), 32'd7);
        do_fetch(8'h10, 2'd1, 24'h000055, 1'b0, 1);

        // Reset in the middle of a fetch.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h10;
        bus.fetch_len  = 2'd3;
        $display("fetch addr=0x10 len=3 (reset mid-fetch)");
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd1);
        bus.fetch_req = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.fetch_valid), 32'd0);
        check("midrst_busy_clr", 32'(bus.busy), 32'd0);
        check("midrst_data", 32'(bus.fetch_data), 32'd0);
        check("midrst_err", 32'(bus.fetch_err), 32'd0);
        check("midrst_count", 32'(bus.load_count), 32'd0);
        check("midrst_ready", 32'(bus.load_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(bus.fetch_valid), 32'd0);
        end
        check("midrst_ready_after", 32'(bus.load_ready), 32'd1);
        do_fetch(8'h10, 2'd1, 24'h0, 1'b1, 0);
        check("midrst_count_after", 32'(bus.load_count), 32'd0);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
